// File: rtl/seq_det_pkg.sv
// rtl/seq_det_pkg.sv - shared types and defaults for the serial pattern detector
package seq_det_pkg;

    typedef enum logic [1:0] {
        PH_EMPTY   = 2'd0,
        PH_FILLING = 2'd1,
        PH_ARMED   = 2'd2
    } fill_phase_t;

    localparam int         CNT_W_DEF   = 8;
    localparam logic [4:0] PAT_RST_DEF = 5'b10111;

    // Classifies a fill level into its detection phase.
    function automatic fill_phase_t phase_of(input int fill, input int pat_w);
        if (fill == 0)
            return PH_EMPTY;
        else if (fill >= pat_w)
            return PH_ARMED;
        else
            return PH_FILLING;
    endfunction

endpackage

// File: rtl/seq_det_sat_cnt.sv
// rtl/seq_det_sat_cnt.sv - saturating incrementer with synchronous clear
module seq_det_sat_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (clr)
            cnt <= '0;
        else if (inc && (cnt != '1))
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/seq_detect_param.sv
// rtl/seq_detect_param.sv - masked serial pattern detector; SEQ_DET_MATCH_CNT_EN builds the match counter
module seq_detect_param
    import seq_det_pkg::*;
#(
    parameter int               PAT_W       = 5,
    parameter logic [PAT_W-1:0] PAT_RST     = PAT_W'(PAT_RST_DEF),
    parameter logic             OVERLAP_RST = 1'b0,
    parameter int               CNT_W       = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             data_vld,
    input  logic             data,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [PAT_W-1:0] cfg_mask,
    input  logic             cfg_overlap,
    output logic             flag,
    output logic [CNT_W-1:0] match_cnt
);

    localparam int               FILL_W    = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

    logic [PAT_W-1:0]  hist;
    logic [PAT_W-1:0]  pat;
    logic [PAT_W-1:0]  mask;
    logic              ovl;
    logic [FILL_W-1:0] fill;

    logic [PAT_W-1:0]  hist_n;
    logic [FILL_W-1:0] fill_n;
    fill_phase_t       phase_n;
    logic              match;
    logic              accept;

    assign accept  = data_vld && !cfg_load;
    assign hist_n  = {hist[PAT_W-2:0], data};
    assign fill_n  = (fill == FILL_FULL) ? FILL_FULL : fill + 1'b1;
    assign phase_n = phase_of(int'(fill_n), PAT_W);
    assign match   = (phase_n == PH_ARMED) && (((hist_n ^ pat) & mask) == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            hist <= '0;
            fill <= '0;
            pat  <= PAT_RST;
            mask <= '1;
            ovl  <= OVERLAP_RST;
            flag <= 1'b0;
        end else if (cfg_load) begin
            // A coincident data bit is dropped: the new pattern starts clean.
            pat  <= cfg_pattern;
            mask <= cfg_mask;
            ovl  <= cfg_overlap;
            hist <= '0;
            fill <= '0;
            flag <= 1'b0;
        end else if (data_vld) begin
            hist <= hist_n;
            fill <= (match && !ovl) ? '0 : fill_n;
            flag <= match;
        end else begin
            flag <= 1'b0;
        end
    end

`ifdef SEQ_DET_MATCH_CNT_EN
    seq_det_sat_cnt #(
        .CNT_W (CNT_W)
    ) u_sat_cnt (
        .clk (clk),
        .clr (rst),
        .inc (accept && match),
        .cnt (match_cnt)
    );
`else
    logic unused_accept;
    assign unused_accept = accept;
    assign match_cnt     = '0;
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
// tb/tb_seq_detect_param.sv - scoreboard bench for seq_detect_param against a bit-list reference model
module tb_seq_detect_param;

    localparam int PAT_W   = 5;
    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             data_vld = 1'b0;
    logic             data = 1'b0;
    logic             cfg_load = 1'b0;
    logic [PAT_W-1:0] cfg_pattern = '0;
    logic [PAT_W-1:0] cfg_mask = '1;
    logic             cfg_overlap = 1'b0;
    logic             flag;
    logic [CNT_W-1:0] match_cnt;

    always #5 clk = ~clk;

    seq_detect_param #(
        .PAT_W       (PAT_W),
        .PAT_RST     (5'b10111),
        .OVERLAP_RST (1'b0),
        .CNT_W       (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .data_vld    (data_vld),
        .data        (data),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_mask    (cfg_mask),
        .cfg_overlap (cfg_overlap),
        .flag        (flag),
        .match_cnt   (match_cnt)
    );

    typedef struct {
        bit flag;
        int cnt;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   total = 0;
    int   bad = 0;
    int   exp_flags = 0;
    int   seen_flags = 0;

    // Reference model: the valid bits received since the last restart, oldest first.
    bit               m_bits[$];
    logic [PAT_W-1:0] m_pat = 5'b10111;
    logic [PAT_W-1:0] m_mask = '1;
    bit               m_ovl = 1'b0;
    int               m_cnt = 0;

    task automatic step(input bit r, input bit v, input bit d, input bit l);
        bit f;
        @(negedge clk);
        rst = r; data_vld = v; data = d; cfg_load = l;
        f = 1'b0;
        if (r) begin
            m_bits.delete();
            m_pat = 5'b10111; m_mask = '1; m_ovl = 1'b0; m_cnt = 0;
        end else if (l) begin
            m_bits.delete();
            m_pat = cfg_pattern; m_mask = cfg_mask; m_ovl = cfg_overlap;
        end else if (v) begin
            m_bits.push_back(d);
            if (m_bits.size() > PAT_W)
                void'(m_bits.pop_front());
            if (m_bits.size() == PAT_W) begin
                f = 1'b1;
                for (int i = 0; i < PAT_W; i++)
                    if (m_mask[PAT_W-1-i] && (m_bits[i] != m_pat[PAT_W-1-i]))
                        f = 1'b0;
            end
            if (f) begin
                if (m_cnt < CNT_MAX) m_cnt++;
                if (!m_ovl) m_bits.delete();
            end
        end
        if (f) exp_flags++;
`ifdef SEQ_DET_MATCH_CNT_EN
        sb.push_back('{f, m_cnt});
`else
        sb.push_back('{f, 0});
`endif
    endtask

    task automatic send(input logic [15:0] seq, input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 1'b1, seq[n-1-i], 1'b0);
            for (int g = 0; g < gap; g++) step(1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic load(input logic [PAT_W-1:0] p, input logic [PAT_W-1:0] m,
                        input bit o, input bit v, input bit d);
        cfg_pattern = p; cfg_mask = m; cfg_overlap = o;
        step(1'b0, v, d, 1'b1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                if (flag === 1'b1) seen_flags++;
                total++;
                if (flag !== e.flag) begin
                    bad++;
                    $display("FAIL flag t=%0t got=%b want=%b", $time, flag, e.flag);
                end
                total++;
                if (match_cnt !== CNT_W'(e.cnt)) begin
                    bad++;
                    $display("FAIL match_cnt t=%0t got=%0d want=%0d", $time, match_cnt, e.cnt);
                end
            end
        end
    end

    initial begin
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        // Default pattern, non-overlap: two back-to-back framed patterns.
        send(16'b1011110111, 10, 0);
        idle(2);
        // Overlapping vs non-overlapping on an alternating stream.
        load(5'b10101, 5'b11111, 1'b1, 1'b0, 1'b0);
        send(16'b1010101, 7, 0);
        load(5'b10101, 5'b11111, 1'b0, 1'b0, 1'b0);
        send(16'b1010101, 7, 0);
        // Don't-care bit in the middle of the pattern.
        load(5'b10111, 5'b11011, 1'b0, 1'b0, 1'b0);
        send(16'b10011, 5, 0);
        // Idle gaps between valid bits.
        load(5'b10111, 5'b11111, 1'b0, 1'b0, 1'b0);
        send(16'b10111, 5, 2);
        // Restart mid-pattern loses the partial match.
        send(16'b101, 3, 0);
        load(5'b10111, 5'b11111, 1'b0, 1'b0, 1'b0);
        send(16'b11, 2, 0);
        // Coincident data bit is discarded by the load.
        load(5'b10111, 5'b11111, 1'b0, 1'b1, 1'b1);
        send(16'b0111, 4, 0);
        send(16'b10111, 5, 0);
        // All-don't-care mask in both modes.
        load(5'b00000, 5'b00000, 1'b1, 1'b0, 1'b0);
        send(16'b1100101, 7, 0);
        load(5'b00000, 5'b00000, 1'b0, 1'b0, 1'b0);
        send(16'b1100101011, 10, 0);
        // Reset mid-pattern, then the default pattern is detected again.
        send(16'b101, 3, 0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        send(16'b10111, 5, 0);
        idle(1);
        // Randomised traffic with occasional reconfiguration and reset.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                load(PAT_W'($urandom), ($urandom_range(0, 5) == 0) ? '0 : PAT_W'($urandom),
                     1'($urandom), 1'($urandom), 1'($urandom));
            end else if ($urandom_range(0, 599) == 0) begin
                step(1'b1, 1'($urandom), 1'($urandom), 1'($urandom));
            end else begin
                step(1'b0, ($urandom_range(0, 3) != 0), 1'($urandom), 1'b0);
            end
        end
        idle(3);
        repeat (3) @(posedge clk);
        #2;
        total++;
        if (seen_flags != exp_flags) begin
            bad++;
            $display("FAIL flag_count got=%0d want=%0d", seen_flags, exp_flags);
        end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain got=%0d want=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
